direction_scoring_engine: RTL

Parametrised successor of the two-car direction scorer: generalises to NUM_ELEV cars and NUM_FLOORS floors with weighted car-call and hall-call scoring. It runs a sequential floor-by-floor scan once per decision period and applies directional persistence (SCAN-style), so a moving car keeps its direction while work remains ahead. It sits between the request/destination registers and the motion controller, and adds single-step evaluation for simulation control.

---
 rtl/direction_scoring_engine_if.sv | 26 ++
 rtl/direction_scoring_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/direction_scoring_engine_if.sv
// Request/position bundle into the direction scorer and its decisions out.
interface direction_scoring_engine_if #(
  parameter int NUM_ELEV   = 2,
  parameter int NUM_FLOORS = 6,
  parameter int POS_W      = 4
);
  logic [1:0]                     simState;
  logic [NUM_ELEV*NUM_FLOORS-1:0] FloorDestinations;
  logic [NUM_ELEV*NUM_FLOORS-1:0] FloorsRequested;
  logic [NUM_ELEV*POS_W-1:0]      half_elevatorPositions;
  logic [NUM_ELEV-1:0]            directions;
  logic [NUM_ELEV-1:0]            moving;
  logic                           scan_done;

  modport master (
    output simState, FloorDestinations, FloorsRequested,
    output half_elevatorPositions,
    input  directions, moving, scan_done
  );

  modport slave (
    input  simState, FloorDestinations, FloorsRequested,
    input  half_elevatorPositions,
    output directions, moving, scan_done
  );
endinterface

// File: rtl/direction_scoring_engine.sv
// Floor-by-floor weighted scan per car with SCAN-style direction
// persistence; one decision per scan, single-step capable.
module direction_scoring_engine #(
  parameter int NUM_ELEV   = 2,
  parameter int NUM_FLOORS = 6,
  parameter int POS_W      = 4,
  parameter int W_DEST     = 2,
  parameter int W_HALL     = 1
) (
  input logic clk,
  input logic rst,
  direction_scoring_engine_if.slave bus
);
  localparam int SCORE_W =
    $clog2(NUM_FLOORS*(W_DEST+W_HALL)+1);
  localparam int CNT_W =
    (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1;
  localparam int CMP_W = POS_W + CNT_W + 1;
  localparam logic [POS_W-1:0] POS_MAX =
    POS_W'(2*(NUM_FLOORS-1));
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(NUM_FLOORS-1);
  localparam logic [1:0] SIM_RUN  = 2'b01;
  localparam logic [1:0] SIM_STEP = 2'b10;

  typedef enum logic [1:0] {
    IDLE, CAPTURE, ACCUM, DECIDE
  } state_t;

  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic step_armed, mode_run, done_q;
  logic run, step, abort, last;
  logic [NUM_ELEV*NUM_FLOORS-1:0] dest_q, req_q;
  logic [NUM_ELEV*POS_W-1:0] pos_q;
  logic [SCORE_W-1:0] up_acc [NUM_ELEV];
  logic [SCORE_W-1:0] dn_acc [NUM_ELEV];
  logic [SCORE_W-1:0] w [NUM_ELEV];
  logic [NUM_ELEV-1:0] above, below;
  logic [NUM_ELEV-1:0] dir_q, mov_q, dir_nx, mov_nx;

  assign run  = (bus.simState == SIM_RUN);
  assign step = (bus.simState == SIM_STEP);
  assign last = (cnt == CNT_LAST);
  // a scan survives only while the mode that started it persists
  assign abort = mode_run ? !run : !step;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (run || (step && step_armed))
          state_nx = CAPTURE;
      CAPTURE:
        state_nx = abort ? IDLE : ACCUM;
      ACCUM:
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DECIDE;
      DECIDE:
        state_nx = run ? CAPTURE : IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      step_armed <= 1'b1;
      mode_run   <= 1'b0;
    end else begin
      state <= state_nx;
      if (!step)
        step_armed <= 1'b1;
      else if (state == IDLE && step_armed)
        step_armed <= 1'b0;
      if (state_nx == CAPTURE)
        mode_run <= run;
    end
  end

  always_comb begin
    for (int e = 0; e < NUM_ELEV; e++) begin
      w[e] = '0;
      if (dest_q[e*NUM_FLOORS + int'(cnt)])
        w[e] = w[e] + SCORE_W'(W_DEST);
      if (req_q[e*NUM_FLOORS + int'(cnt)])
        w[e] = w[e] + SCORE_W'(W_HALL);
      above[e] = CMP_W'({cnt, 1'b0}) >
                 CMP_W'(pos_q[e*POS_W +: POS_W]);
      below[e] = CMP_W'({cnt, 1'b0}) <
                 CMP_W'(pos_q[e*POS_W +: POS_W]);
    end
  end

  always_comb begin
    for (int e = 0; e < NUM_ELEV; e++) begin
      dir_nx[e] = dir_q[e];
      mov_nx[e] = mov_q[e];
      if (up_acc[e] == '0 && dn_acc[e] == '0) begin
        mov_nx[e] = 1'b0;
      end else begin
        mov_nx[e] = 1'b1;
        if (mov_q[e])
          dir_nx[e] = dir_q[e] ? (up_acc[e] != '0)
                               : (dn_acc[e] == '0);
        else if (up_acc[e] > dn_acc[e])
          dir_nx[e] = 1'b1;
        else if (dn_acc[e] > up_acc[e])
          dir_nx[e] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      dest_q <= '0;
      req_q  <= '0;
      pos_q  <= '0;
      for (int e = 0; e < NUM_ELEV; e++) begin
        up_acc[e] <= '0;
        dn_acc[e] <= '0;
      end
    end else if (state == CAPTURE) begin
      cnt    <= '0;
      dest_q <= bus.FloorDestinations;
      req_q  <= bus.FloorsRequested;
      for (int e = 0; e < NUM_ELEV; e++) begin
        up_acc[e] <= '0;
        dn_acc[e] <= '0;
        pos_q[e*POS_W +: POS_W] <=
          (bus.half_elevatorPositions[e*POS_W +: POS_W]
            > POS_MAX) ? POS_MAX
          : bus.half_elevatorPositions[e*POS_W +: POS_W];
      end
    end else if (state == ACCUM) begin
      cnt <= last ? '0 : cnt + 1'b1;
      for (int e = 0; e < NUM_ELEV; e++) begin
        if (above[e]) up_acc[e] <= up_acc[e] + w[e];
        if (below[e]) dn_acc[e] <= dn_acc[e] + w[e];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q  <= '0;
      mov_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == DECIDE);
      if (state == DECIDE) begin
        dir_q <= dir_nx;
        mov_q <= mov_nx;
      end
    end
  end

  assign bus.directions = dir_q;
  assign bus.moving     = mov_q;
  assign bus.scan_done  = done_q;
endmodule
